dht_reader: RTL and testbench
=============================

# dht_reader

Parametrised single-wire reader for DHT11/DHT22-class humidity/temperature sensors. It drives the host start pulse through an open-drain enable and decodes the sensor's 40-bit frame by pulse-width timing. It verifies the checksum and presents humidity and temperature words with a valid strobe. It sits between the bidirectional sensor pad (tristate buffer instantiated at top level) and the system logic, and supports manual-trigger or periodic auto-sampling.

## Interface
- CLK_HZ, 100_000_000: clk frequency; all timings derived as ticks = us * (CLK_HZ/1_000_000).
- START_LOW_US, 18000: host start-pulse low time.
- BIT_THRESH_US, 50: data-bit high time strictly greater than this decodes as 1.
- TIMEOUT_US, 200: maximum duration of any sensor-driven phase.
- HOLDOFF_MS, 1000: minimum gap from end of one transaction to next start.
- AUTO_PERIOD_MS, 0: 0 = manual only; otherwise auto-start every period, counted from end of previous transaction.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a transaction.
- dq_i  in  1  pad input, asynchronous.
- dq_oe  out  1  1 = pad driven low, 0 = released (pulled high externally).
- busy  out  1  high whenever state is not IDLE.
- data_valid  out  1  one-cycle pulse, new good frame.
- humidity  out  16  frame bits [39:24].
- temperature  out  16  frame bits [23:8].
- checksum_err  out  1  one-cycle pulse, checksum mismatch.
- timeout_err  out  1  one-cycle pulse, phase timeout.

## Operation
- dq_i passes through a 2-flop synchroniser (flops reset to 1); all decisions use the synchronised value, edges detected against a third registered copy.
- States: IDLE, START_LOW, RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, CHECK.
- IDLE: start (or auto-period expiry) with holdoff counter zero -> START_LOW, timer cleared. Otherwise request ignored (not queued).
- START_LOW: dq_oe=1 for exactly START_LOW ticks -> RELEASE, dq_oe=0.
- RELEASE: wait sensor low -> ACK_LOW. ACK_LOW: wait high -> ACK_HIGH. ACK_HIGH: wait low -> BIT_LOW, bit counter=0.
- BIT_LOW: wait high -> BIT_HIGH, timer cleared. BIT_HIGH: count ticks; on falling edge shift bit (count > BIT_THRESH ticks) into 40-bit register MSB first, increment bit counter; after 40th bit -> CHECK, else -> BIT_LOW.
- Timer clears on every state transition; reaching TIMEOUT ticks in any of RELEASE..BIT_HIGH -> timeout_err pulse, IDLE.
- CHECK (one cycle): sum = ([39:32]+[31:24]+[23:16]+[15:8]) mod 256, computed 10-bit then truncated. Equal to [7:0]: load humidity/temperature, pulse data_valid. Else pulse checksum_err, outputs hold previous values. -> IDLE.
- Every return to IDLE (success or error) loads holdoff counter with HOLDOFF_MS ticks and restarts the auto-period counter.
- dq_oe is 1 only in START_LOW.

## Timing
- Reset: dq_oe=0 (asynchronously), busy=0, data_valid=0, checksum_err=0, timeout_err=0, humidity=0, temperature=0, state IDLE, holdoff=0 (start accepted on first cycle after reset release).
- start sampled at cycle N in IDLE -> dq_oe=1 and busy=1 from cycle N+1.
- dq_oe low exactly START_LOW ticks (±0 cycles).
- Pad edge to state reaction: 3 cycles (sync + edge register).
- Last bit falling edge at pad -> data_valid/checksum_err high 4 cycles later, for 1 cycle; humidity/temperature update on the same edge as data_valid.
- Simultaneous start and auto expiry: one transaction. start while busy or in holdoff: ignored.
- Reset mid-transaction: bus released immediately, partial frame discarded, no strobes.
- Bit high time exactly BIT_THRESH ticks decodes as 0.

## Test plan
Use CLK_HZ=1_000_000, START_LOW_US=100, HOLDOFF_MS=1, AUTO_PERIOD_MS=0.
- Good frame 0x01F4_00FA_EF (DHT22 50.0%/25.0°C) -> dq_oe high 100 cycles, data_valid one pulse, humidity=0x01F4, temperature=0x00FA.
- Same frame with checksum byte 0xEE -> checksum_err one pulse, no data_valid, humidity/temperature remain at previous values.
- Sensor never responds after release -> timeout_err exactly 200 ticks after RELEASE entry, busy falls, dq_oe=0.
- Bit high times 50 and 51 ticks -> decoded 0 and 1 respectively.
- start pulsed while busy and 500 cycles after completion -> both ignored; start at 1000+ cycles -> accepted.
- Assert rst during bit 20 -> dq_oe=0, busy=0 immediately; no strobes; next start after release runs a full good frame.

Source files
------------

// File: rtl/dht_reader.sv
// dht_reader: single-wire DHT11/DHT22 reader. Drives the host start pulse through an
// open-drain enable, decodes the 40-bit frame by pulse width, checks the checksum and
// presents humidity/temperature with a one-cycle valid strobe.
module dht_reader #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned START_LOW_US   = 18000,
    parameter int unsigned BIT_THRESH_US  = 50,
    parameter int unsigned TIMEOUT_US     = 200,
    parameter int unsigned HOLDOFF_MS     = 1000,
    parameter int unsigned AUTO_PERIOD_MS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dq_i,
    output logic        dq_oe,
    output logic        busy,
    output logic        data_valid,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        checksum_err,
    output logic        timeout_err
);

    localparam int unsigned TPU           = CLK_HZ / 1_000_000;
    localparam int unsigned START_TICKS   = START_LOW_US * TPU;
    localparam int unsigned THRESH_TICKS  = BIT_THRESH_US * TPU;
    localparam int unsigned TIMEOUT_TICKS = TIMEOUT_US * TPU;
    localparam int unsigned HOLDOFF_TICKS = HOLDOFF_MS * 1000 * TPU;
    localparam int unsigned AUTO_TICKS    = AUTO_PERIOD_MS * 1000 * TPU;

    localparam int unsigned TIMER_MAX = (START_TICKS > TIMEOUT_TICKS) ? START_TICKS
                                                                     : TIMEOUT_TICKS;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX + 1) : 1;
    localparam int unsigned HOLD_W    = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS + 1) : 1;
    localparam int unsigned AUTO_W    = (AUTO_TICKS > 1) ? $clog2(AUTO_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStartLow,
        StRelease,
        StAckLow,
        StAckHigh,
        StBitLow,
        StBitHigh,
        StCheck
    } state_e;

    state_e               state;
    logic [TIMER_W-1:0]   timer;
    logic [5:0]           bit_cnt;
    logic [39:0]          frame;
    logic [HOLD_W-1:0]    holdoff;
    logic [AUTO_W-1:0]    auto_cnt;

    logic dq_s1, dq_s2, dq_prev;
    logic dq_fall, dq_rise;
    logic phase_edge;
    logic timed_out;
    logic bit_val;
    logic auto_fire;
    logic [7:0] sum;

    assign dq_fall   = dq_prev & ~dq_s2;
    assign dq_rise   = ~dq_prev & dq_s2;
    assign timed_out = (timer == TIMER_W'(TIMEOUT_TICKS - 1));
    // timer holds ticks-1 on the cycle the falling edge is seen, so >= means "> threshold"
    assign bit_val   = (timer >= TIMER_W'(THRESH_TICKS));
    assign auto_fire = (AUTO_TICKS != 0) && (auto_cnt == '0);
    // Modulo-256 sum by truncation to 8 bits
    assign sum       = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];

    // Pad synchroniser plus a third copy for edge detection; idle bus reads high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_s1   <= 1'b1;
            dq_s2   <= 1'b1;
            dq_prev <= 1'b1;
        end else begin
            dq_s1   <= dq_i;
            dq_s2   <= dq_s1;
            dq_prev <= dq_s2;
        end
    end

    // Select the bus edge that ends the current sensor-driven phase
    always_comb begin
        phase_edge = 1'b0;
        unique case (state)
            StRelease, StAckHigh, StBitHigh: phase_edge = dq_fall;
            StAckLow, StBitLow:              phase_edge = dq_rise;
            default:                         phase_edge = 1'b0;
        endcase
    end

    // Holdoff and auto-period counters: held at full value while busy, so they start
    // counting down from the first idle cycle after any transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdoff  <= '0;
            auto_cnt <= AUTO_W'(AUTO_TICKS);
        end else if (state != StIdle) begin
            holdoff  <= HOLD_W'(HOLDOFF_TICKS);
            auto_cnt <= AUTO_W'(AUTO_TICKS);
        end else begin
            if (holdoff != '0) holdoff <= holdoff - 1'b1;
            if (auto_cnt != '0) auto_cnt <= auto_cnt - 1'b1;
        end
    end

    // Transaction FSM with registered bus enable, status and result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            timer        <= '0;
            bit_cnt      <= '0;
            frame        <= '0;
            dq_oe        <= 1'b0;
            busy         <= 1'b0;
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
        end else begin
            data_valid   <= 1'b0;
            checksum_err <= 1'b0;
            timeout_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if ((start || auto_fire) && holdoff == '0) begin
                        state <= StStartLow;
                        timer <= '0;
                        dq_oe <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                StStartLow: begin
                    if (timer == TIMER_W'(START_TICKS - 1)) begin
                        state <= StRelease;
                        timer <= '0;
                        dq_oe <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StRelease, StAckLow, StAckHigh, StBitLow, StBitHigh: begin
                    if (phase_edge) begin
                        timer <= '0;
                        unique case (state)
                            StRelease: state <= StAckLow;
                            StAckLow:  state <= StAckHigh;
                            StAckHigh: begin
                                state   <= StBitLow;
                                bit_cnt <= '0;
                            end
                            StBitLow:  state <= StBitHigh;
                            default: begin
                                frame   <= {frame[38:0], bit_val};
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= (bit_cnt == 6'd39) ? StCheck : StBitLow;
                            end
                        endcase
                    end else if (timed_out) begin
                        state       <= StIdle;
                        timer       <= '0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                StCheck: begin
                    if (sum == frame[7:0]) begin
                        humidity    <= frame[39:24];
                        temperature <= frame[23:8];
                        data_valid  <= 1'b1;
                    end else begin
                        checksum_err <= 1'b1;
                    end
                    state <= StIdle;
                    timer <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    dq_oe <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht_reader.sv
// tb_dht_reader: directed bench with a behavioural sensor and a strobe scoreboard.
module tb_dht_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sensor_low;
    logic        dq_i;
    logic        dq_oe;
    logic        busy;
    logic        data_valid;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic        checksum_err;
    logic        timeout_err;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] hum;
        logic [15:0] temp;
    } exp_t;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_CSUM  = 3'b010;
    localparam logic [2:0] K_TOUT  = 3'b001;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_hum = 16'h0000;
    logic [15:0] exp_temp = 16'h0000;

    always #5 clk = ~clk;

    // Open-drain bus with external pull-up
    assign dq_i = ~(dq_oe | sensor_low);

    dht_reader #(
        .CLK_HZ        (1_000_000),
        .START_LOW_US  (100),
        .BIT_THRESH_US (50),
        .TIMEOUT_US    (200),
        .HOLDOFF_MS    (1),
        .AUTO_PERIOD_MS(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dq_i        (dq_i),
        .dq_oe       (dq_oe),
        .busy        (busy),
        .data_valid  (data_valid),
        .humidity    (humidity),
        .temperature (temperature),
        .checksum_err(checksum_err),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] k);
        exp_t e;
        e.kind = k;
        e.hum  = exp_hum;
        e.temp = exp_temp;
        sb.push_back(e);
    endtask

    // Every strobe must match the oldest expectation, including held result words
    always @(negedge clk) begin
        if (rst === 1'b1 && (data_valid || checksum_err || timeout_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 40'({data_valid, checksum_err, timeout_err}), 40'd0);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", 40'({data_valid, checksum_err, timeout_err}),
                      40'(mon_e.kind));
                check("humidity", 40'(humidity), 40'(mon_e.hum));
                check("temperature", 40'(temperature), 40'(mon_e.temp));
            end
        end
    end

    task automatic do_start(input logic accept);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 40'(busy), 40'(accept));
        check("start_dq_oe", 40'(dq_oe), 40'(accept));
    endtask

    task automatic measure_oe();
        int n;
        n = 0;
        while (dq_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("start_low_len", 40'(n), 40'd100);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 40'(sb.size()), 40'd0);
    endtask

    // Sensor response; thr selects 50/51-tick bit highs, stop_bit aborts mid-frame
    task automatic run_sensor(input logic [39:0] f, input bit thr, input bit poke,
                              input int stop_bit);
        int hi;
        int n;
        repeat (20) @(negedge clk);
        sensor_low = 1'b1;
        repeat (40) @(negedge clk);
        if (poke) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_while_busy", 40'(busy), 40'd1);
        end else begin
            @(negedge clk);
        end
        repeat (39) @(negedge clk);
        sensor_low = 1'b0;
        repeat (80) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            sensor_low = 1'b1;
            repeat (50) @(negedge clk);
            sensor_low = 1'b0;
            if (i == stop_bit) begin
                repeat (10) @(negedge clk);
                return;
            end
            if (f[39-i]) hi = thr ? 51 : 70;
            else         hi = thr ? 50 : 26;
            repeat (hi) @(negedge clk);
        end
        sensor_low = 1'b1;
        n = 0;
        while (!(data_valid || checksum_err) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("strobe_latency", 40'(n), 40'd4);
        sensor_low = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        sensor_low = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_dq_oe", 40'(dq_oe), 40'd0);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_strobes", 40'({data_valid, checksum_err, timeout_err}), 40'd0);
        check("rst_humidity", 40'(humidity), 40'd0);
        check("rst_temperature", 40'(temperature), 40'd0);
        @(negedge clk);
        rst = 1'b1;

        // Good frame, nominal timing
        do_start(1'b1);
        measure_oe();
        exp_hum  = 16'h01F4;
        exp_temp = 16'h00FA;
        push(K_VALID);
        run_sensor(40'h01F4_00FA_EF, 1'b0, 1'b0, 99);
        drain();

        // Start inside holdoff is dropped; after holdoff it is taken
        repeat (498) @(negedge clk);
        do_start(1'b0);
        repeat (499) @(negedge clk);
        do_start(1'b1);
        measure_oe();
        push(K_CSUM);
        run_sensor(40'h01F4_00FA_EE, 1'b0, 1'b1, 99);
        check("idle_after_frame", 40'(busy), 40'd0);
        drain();

        // Threshold timing: zeros high 50 ticks, ones high 51 ticks
        repeat (1001) @(negedge clk);
        do_start(1'b1);
        measure_oe();
        exp_hum  = 16'h0285;
        exp_temp = 16'h80C3;
        push(K_VALID);
        run_sensor(40'h0285_80C3_CA, 1'b1, 1'b0, 99);
        drain();

        // Silent sensor
        repeat (1001) @(negedge clk);
        do_start(1'b1);
        measure_oe();
        push(K_TOUT);
        n = 0;
        while (!timeout_err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_delay", 40'(n), 40'd200);
        check("timeout_busy", 40'(busy), 40'd0);
        check("timeout_dq_oe", 40'(dq_oe), 40'd0);
        drain();

        // Reset during bit 20, then a full frame straight after reset
        repeat (1001) @(negedge clk);
        do_start(1'b1);
        measure_oe();
        run_sensor(40'h0190_0118_AA, 1'b0, 1'b0, 20);
        check("pre_reset_busy", 40'(busy), 40'd1);
        rst = 1'b0;
        #1;
        check("mid_reset_busy", 40'(busy), 40'd0);
        check("mid_reset_dq_oe", 40'(dq_oe), 40'd0);
        exp_hum  = 16'h0000;
        exp_temp = 16'h0000;
        check("mid_reset_humidity", 40'(humidity), 40'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        do_start(1'b1);
        measure_oe();
        exp_hum  = 16'h0190;
        exp_temp = 16'h0118;
        push(K_VALID);
        run_sensor(40'h0190_0118_AA, 1'b0, 1'b0, 99);
        drain();
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
